// File: rtl/serial_byte_rx.sv
// LSB-first serial frame receiver (start, data, optional even parity, stop) feeding a
// single-entry output slot with a valid/ready handshake and registered error pulses.
module serial_byte_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sdi,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [DATA_W-1:0]   shreg_r;
  logic [DATA_W-1:0]   data_out_r;
  logic                data_valid_r;
  logic                busy_r;
  logic                perr_r;
  logic                frame_err_r;
  logic                parity_err_r;
  logic                overrun_r;

  logic                stop_sample_s;
  logic                good_frame_s;
  logic                load_s;
  logic                consume_s;

  // Even parity of the assembled data word: 1 when it holds an odd number of ones.
  function automatic logic even_parity_f(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  assign stop_sample_s = bit_en & (state_r == STOP);
  assign good_frame_s  = stop_sample_s & sdi & ~perr_r;
  // A good frame may land in the slot when it is empty or being drained this very cycle.
  assign load_s        = good_frame_s & (~data_valid_r | data_ready);
  assign consume_s     = data_valid_r & data_ready & ~load_s;

  // Frame FSM, output slot and error pulses.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= '0;
      shreg_r      <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      perr_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= good_frame_s & ~load_s;

      if (load_s) begin
        data_out_r   <= shreg_r;
        data_valid_r <= 1'b1;
      end else if (consume_s) begin
        data_valid_r <= 1'b0;
      end else begin
        data_valid_r <= data_valid_r;
      end

      if (bit_en) begin
        case (state_r)
          IDLE: begin
            if (!sdi) begin
              state_r   <= DATA;
              bit_cnt_r <= '0;
              busy_r    <= 1'b1;
            end else begin
              state_r   <= IDLE;
            end
          end
          DATA: begin
            shreg_r   <= {sdi, shreg_r[DATA_W-1:1]};
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
            if (bit_cnt_r == LAST_CNT) begin
              state_r <= PARITY_EN ? PARITY : STOP;
            end else begin
              state_r <= DATA;
            end
          end
          PARITY: begin
            perr_r  <= even_parity_f(shreg_r) ^ sdi;
            state_r <= STOP;
          end
          STOP: begin
            // Errors discard the byte; the line is not resynchronised afterwards.
            frame_err_r  <= ~sdi;
            parity_err_r <= perr_r & PARITY_EN;
            perr_r       <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
          default: begin
            perr_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign busy       = busy_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;

endmodule
